// File: rtl/hec_pkg.sv
// Shared definitions for the hybrid entropy coder: packer states and
// accumulator / length widths used by the codeword packer.
package hec_pkg;

    localparam int ACC_WIDTH             = 64;
    localparam int OUT_WIDTH_DEF         = 32;
    localparam int ENCODE_DATALENGTH_DEF = 21;
    localparam int LEN_WIDTH             = 6;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_PAD,
        ST_DONE
    } packer_state_e;

endpackage : hec_pkg

// File: rtl/codeword_merge.sv
// Combinational merge of one right-aligned codeword into the MSB-aligned
// accumulator at bit position 63-cnt; kept separate so the barrel shift is isolated.
module codeword_merge
    import hec_pkg::*;
#(
    parameter int ENCODE_DATALENGTH = ENCODE_DATALENGTH_DEF
) (
    input  logic [ACC_WIDTH-1:0]         acc_i,
    input  logic [LEN_WIDTH-1:0]         cnt_i,
    input  logic [ENCODE_DATALENGTH-1:0] data_i,
    input  logic [LEN_WIDTH-1:0]         len_i,
    output logic [ACC_WIDTH-1:0]         acc_o
);

    logic [ACC_WIDTH-1:0] data_ext;
    logic [ACC_WIDTH-1:0] len_mask;
    logic [ACC_WIDTH-1:0] aligned;
    logic [LEN_WIDTH:0]   shamt;

    always_comb begin
        data_ext = {{(ACC_WIDTH-ENCODE_DATALENGTH){1'b0}}, data_i};
        // Bits above len are not guaranteed zero by the codebook, so mask them off.
        len_mask = (ACC_WIDTH'(1) << len_i) - ACC_WIDTH'(1);
        shamt    = (LEN_WIDTH+1)'(ACC_WIDTH) - {1'b0, len_i} - {1'b0, cnt_i};
        aligned  = (data_ext & len_mask) << shamt;
        acc_o    = acc_i | aligned;
    end

endmodule : codeword_merge

// File: rtl/codeword_packer.sv
// Packs variable-length codewords (MSB first) into a gap-free stream of
// OUT_WIDTH-bit words; a flush zero-pads and tags the final partial word.
module codeword_packer
    import hec_pkg::*;
#(
    parameter int ENCODE_DATALENGTH = ENCODE_DATALENGTH_DEF,
    parameter int OUT_WIDTH         = OUT_WIDTH_DEF
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         cw_valid_i,
    output logic                         cw_ready_o,
    input  logic [LEN_WIDTH-1:0]         cw_length_i,
    input  logic [ENCODE_DATALENGTH-1:0] cw_data_i,
    input  logic                         flush_i,
    output logic                         word_valid_o,
    input  logic                         word_ready_i,
    output logic [OUT_WIDTH-1:0]         word_data_o,
    output logic                         word_last_o,
    output logic [LEN_WIDTH-1:0]         word_fill_o,
    output logic                         flush_done_o,
    output logic                         len_err_o
);

    localparam logic [LEN_WIDTH-1:0] OUT_W_L = LEN_WIDTH'(OUT_WIDTH);
    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(ENCODE_DATALENGTH);

    packer_state_e          state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   word_valid_q, word_valid_d;
    logic [OUT_WIDTH-1:0]   word_data_q, word_data_d;
    logic                   word_last_q, word_last_d;
    logic [LEN_WIDTH-1:0]   word_fill_q, word_fill_d;
    logic                   len_err_q, len_err_d;

    logic [ACC_WIDTH-1:0]   acc_merged;
    logic [OUT_WIDTH-1:0]   pad_mask;
    logic                   slot_free;
    logic                   accept;

    codeword_merge #(
        .ENCODE_DATALENGTH (ENCODE_DATALENGTH)
    ) u_merge (
        .acc_i  (acc_q),
        .cnt_i  (cnt_q),
        .data_i (cw_data_i),
        .len_i  (cw_length_i),
        .acc_o  (acc_merged)
    );

    assign cw_ready_o   = (state_q == ST_RUN) && (cnt_q < OUT_W_L);
    assign slot_free    = !word_valid_q || word_ready_i;
    assign accept       = cw_valid_i && cw_ready_o;
    assign pad_mask     = ~({OUT_WIDTH{1'b1}} >> cnt_q);
    assign flush_done_o = (state_q == ST_DONE);

    always_comb begin
        // NOTE: every _d takes its hold value first so no path through this block infers a latch.
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        word_valid_d = word_valid_q && !word_ready_i;
        word_data_d  = word_data_q;
        word_last_d  = word_last_q;
        word_fill_d  = word_fill_q;
        len_err_d    = len_err_q;

        // Full-word move is state independent; accept needs cnt < OUT_WIDTH so they never collide.
        if ((cnt_q >= OUT_W_L) && slot_free) begin
            word_valid_d = 1'b1;
            word_data_d  = acc_q[ACC_WIDTH-1 -: OUT_WIDTH];
            word_fill_d  = OUT_W_L;
            word_last_d  = 1'b0;
            acc_d        = acc_q << OUT_WIDTH;
            cnt_d        = cnt_q - OUT_W_L;
        end

        if (accept) begin
            if (cw_length_i > MAX_LEN) begin
                len_err_d = 1'b1;
            end else begin
                acc_d = acc_merged;
                cnt_d = cnt_q + cw_length_i;
            end
        end

        unique case (state_q)
            ST_RUN: begin
                if (flush_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (cnt_q < OUT_W_L) state_d = (cnt_q != '0) ? ST_PAD : ST_DONE;
            end
            ST_PAD: begin
                if (slot_free) begin
                    word_valid_d = 1'b1;
                    word_data_d  = acc_q[ACC_WIDTH-1 -: OUT_WIDTH] & pad_mask;
                    word_fill_d  = cnt_q;
                    word_last_d  = 1'b1;
                    cnt_d        = '0;
                    acc_d        = '0;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_RUN;
            acc_q        <= '0;
            cnt_q        <= '0;
            word_valid_q <= 1'b0;
            word_data_q  <= '0;
            word_last_q  <= 1'b0;
            word_fill_q  <= '0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            word_valid_q <= word_valid_d;
            word_data_q  <= word_data_d;
            word_last_q  <= word_last_d;
            word_fill_q  <= word_fill_d;
            len_err_q    <= len_err_d;
        end
    end

    assign word_valid_o = word_valid_q;
    assign word_data_o  = word_data_q;
    assign word_last_o  = word_last_q;
    assign word_fill_o  = word_fill_q;
    assign len_err_o    = len_err_q;

endmodule : codeword_packer
